inst_loader: RTL
================

# inst_loader

Program loader that writes into the writable instruction memory of the single-cycle CPU. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. Each word is written to consecutive word-aligned addresses of the 32-word instruction store, which is indexed by Addr[6:2]. The CPU is held off while loading and released on a clean end-of-program.

## Interface
- WORDS, 32, instruction store depth in words; Word_count saturates here
- Clk  in  1  rising-edge clock
- Clrn  in  1  reset, synchronous, active-low
- Start  in  1  begin (or restart) a load; single-cycle pulse
- Byte_in  in  8  program byte, MSB-first within each word
- Byte_valid  in  1  Byte_in is valid
- Last  in  1  qualifies the accepted byte as the final byte of the program
- Byte_ready  out  1  loader accepts a byte this cycle
- Wr_en  out  1  instruction-memory write strobe, one cycle per word
- Wr_addr  out  32  byte address of the word, always {25'b0, idx[4:0], 2'b00}
- Wr_data  out  32  assembled instruction word
- Word_count  out  6  words written in the current load, 0..WORDS
- Cpu_hold  out  1  keep the CPU in reset / PC at 0
- Done  out  1  load completed cleanly
- Err  out  1  load aborted (misaligned Last or overflow)

## Operation
- States: IDLE, LOAD, WRITE, DONE, ERR.
- Reset (Clrn=0 at an edge), from any state including mid-word or mid-WRITE:
  - state=IDLE; all outputs 0; shift register, byte counter and index cleared.
  - No Wr_en is issued for a partial word.
- IDLE: Cpu_hold=0. Start -> LOAD.
- On any transition into LOAD from Start, clear byte_cnt, idx, Word_count, Done and Err.
- LOAD: Byte_ready=1, Cpu_hold=1. A byte is accepted when Byte_valid & Byte_ready.
  - Shift: shreg <= {shreg[23:0], Byte_in}; byte_cnt <= byte_cnt+1 (2-bit, wraps 3->0).
  - Accepted byte with byte_cnt==3 -> WRITE; latch Last into last_q.
  - Accepted byte with Last=1 and byte_cnt!=3 -> ERR (misaligned program).
  - Accepted byte while Word_count==WORDS -> ERR (overflow); byte consumed, no write.
- WRITE (exactly one cycle): Byte_ready=0; Wr_en=1, Wr_data=shreg, Wr_addr=idx<<2.
  - At exit: idx++, Word_count++.
  - last_q=1 -> DONE; else -> LOAD.
- DONE: Done=1, Cpu_hold=0, Byte_ready=0. Bytes are ignored. Start -> LOAD (reload).
- ERR: Err=1, Cpu_hold=1, Byte_ready=0. Bytes are ignored. Start -> LOAD.
- Start in LOAD or WRITE restarts the load:
  - Start in WRITE: the pending write still completes this cycle, then counters clear and state=LOAD.
  - Start in LOAD on the same edge as an accepted byte: the byte is discarded and the restart wins.
- Start in IDLE while Byte_valid=1: the byte is not accepted; Byte_ready is 0 in IDLE.

## Timing
- Byte_ready, Wr_en, Cpu_hold, Done and Err are decoded from the registered state only; no combinational path from inputs.
- 4th byte of a word accepted at edge N:
  - Wr_en/Wr_addr/Wr_data are valid during cycle N..N+1; memory captures at edge N+1.
  - Byte_ready returns to 1 after edge N+1.
- Throughput: one word per 5 cycles at full Byte_valid.
- Final word (Last accepted at edge N): Done=1 and Cpu_hold=0 after edge N+1, the same edge the last write completes.
- Wr_addr and Wr_data hold their values outside WRITE and are don't-care while Wr_en=0.
- Word_count increments at the edge ending WRITE; after a write at address 0x7C it reads 32.

## Test plan
- Reset: Clrn=0 for 2 cycles -> state IDLE; Byte_ready=Wr_en=Cpu_hold=Done=Err=0; Word_count=0.
- Single word: Start, then bytes 20,41,00,10 with Last on the 4th:
  - One Wr_en with Wr_addr=0x0, Wr_data=0x20410010.
  - Done=1 and Cpu_hold=0 one cycle later; Word_count=1.
- Two words with Byte_valid gaps: 0x30220010 then 0x34230010 (Last) -> writes at 0x0 and 0x4 in order, Done=1, Word_count=2; no write occurs during gaps.
- Full store: 32 words with Last on byte 128 -> final write at 0x7C, Done=1, Word_count=32.
  - Repeat without Last plus one extra byte -> Err=1, Cpu_hold=1, no 33rd Wr_en.
- Misaligned Last on byte 6 -> one write only (word 0), then Err=1, Cpu_hold=1.
  - Then Start plus 4 good bytes with Last -> Err=0, Done=1, write at 0x0.
- Clrn=0 after 2 bytes of word 1 -> IDLE, no Wr_en. Start during WRITE -> that write completes, next word's address is 0x0.

Source files
------------

// File: rtl/inst_loader.sv
// Byte-stream program loader for the single-cycle CPU's writable instruction store.
// Packs big-endian bytes into 32-bit words and writes them to consecutive word addresses.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no load in progress, CPU free to run
// S_LOAD  | accepting bytes, CPU held
// S_WRITE | one-cycle instruction-memory write of the assembled word
// S_DONE  | program loaded cleanly, CPU released
// S_ERR   | load aborted (misaligned Last or overflow), CPU held
module inst_loader #(
    parameter int WORDS = 32
) (
    input  logic        i_clk,
    input  logic        i_clrn,
    input  logic        i_start,
    input  logic [7:0]  i_byte_in,
    input  logic        i_byte_valid,
    input  logic        i_last,
    output logic        o_byte_ready,
    output logic        o_wr_en,
    output logic [31:0] o_wr_addr,
    output logic [31:0] o_wr_data,
    output logic [5:0]  o_word_count,
    output logic        o_cpu_hold,
    output logic        o_done,
    output logic        o_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    localparam logic [5:0] WORDS_C = 6'(WORDS);

    logic [2:0]  r_state;
    logic [31:0] r_shreg;
    logic [1:0]  r_byte_cnt;
    logic [4:0]  r_idx;
    logic [5:0]  r_word_count;
    logic        r_last_q;
    logic [31:0] r_wr_addr;
    logic [31:0] r_wr_data;

    logic [31:0] w_shreg_nxt;
    assign w_shreg_nxt = {r_shreg[23:0], i_byte_in};

    always_ff @(posedge i_clk) begin
        if (!i_clrn) begin
            r_state      <= S_IDLE;
            r_shreg      <= '0;
            r_byte_cnt   <= '0;
            r_idx        <= '0;
            r_word_count <= '0;
            r_last_q     <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
        end else if (i_start) begin
            // Restart from any state; a write in progress has already been presented this cycle.
            r_state      <= S_LOAD;
            r_shreg      <= '0;
            r_byte_cnt   <= '0;
            r_idx        <= '0;
            r_word_count <= '0;
            r_last_q     <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (i_byte_valid) begin
                        if (r_word_count == WORDS_C) begin
                            r_state <= S_ERR;
                        end else begin
                            r_shreg    <= w_shreg_nxt;
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                            if (r_byte_cnt == 2'd3) begin
                                // Output registers hold the word so Wr_addr/Wr_data stay stable outside WRITE.
                                r_state   <= S_WRITE;
                                r_last_q  <= i_last;
                                r_wr_data <= w_shreg_nxt;
                                r_wr_addr <= {25'b0, r_idx, 2'b00};
                            end else if (i_last) begin
                                r_state <= S_ERR;
                            end
                        end
                    end
                end
                S_WRITE: begin
                    r_idx        <= r_idx + 5'd1;
                    r_word_count <= r_word_count + 6'd1;
                    r_state      <= r_last_q ? S_DONE : S_LOAD;
                end
                S_IDLE, S_DONE, S_ERR: begin
                    r_state <= r_state;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_byte_ready = (r_state == S_LOAD);
    assign o_wr_en      = (r_state == S_WRITE);
    assign o_cpu_hold   = (r_state == S_LOAD) || (r_state == S_WRITE) || (r_state == S_ERR);
    assign o_done       = (r_state == S_DONE);
    assign o_err        = (r_state == S_ERR);
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_data    = r_wr_data;
    assign o_word_count = r_word_count;

endmodule
